// File: rtl/led_pattern_sequencer.sv
// AXI-lite write-only master that paces LED pattern updates with a tick timer.
// A pattern is committed to the local copy only after an OKAY write response.
module led_pattern_sequencer #(
    parameter logic [31:0] LED_ADDR = 32'h4000_0000,
    parameter int          TICK_W   = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [TICK_W-1:0] period,
    input  logic [7:0]        seed,
    output logic [31:0]       m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [7:0]        pattern,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] last;
    logic              tick;
    logic              pending;
    logic              dir;
    logic [7:0]        next_q;
    logic [1:0]        mode_q;
    logic [7:0]        nxt;
    logic              onehot;
    logic              aw_fin;
    logic              w_fin;

    // A period of zero behaves exactly like a period of one.
    assign last   = (period == '0) ? '0 : period - TICK_W'(1);
    assign tick   = enable && (cnt >= last);
    assign onehot = (pattern != 8'h00) &&
                    ((pattern & (pattern - 8'd1)) == 8'h00);
    assign aw_fin = !m_awvalid || m_awready;
    assign w_fin  = !m_wvalid || m_wready;
    assign busy   = (state != IDLE);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

    // dir: 0 = shifting left, 1 = shifting right
    always_comb begin
        nxt = 8'h00;
        case (mode)
            2'b00: nxt = seed;
            2'b01: nxt = pattern + 8'd1;
            2'b10: nxt = (pattern == 8'h00) ? 8'h01 :
                         {pattern[6:0], pattern[7]};
            default: begin
                if (!onehot) begin
                    nxt = 8'h01;
                end else if (dir) begin
                    nxt = pattern >> 1;
                end else begin
                    nxt = pattern << 1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            m_awaddr  <= 32'h0;
            m_awvalid <= 1'b0;
            m_wdata   <= 32'h0;
            m_wstrb   <= 4'b0000;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            pattern   <= 8'h00;
            err_cnt   <= 8'h00;
            dir       <= 1'b0;
            next_q    <= 8'h00;
            mode_q    <= 2'b00;
        end else begin
            // A starting transfer consumes both the stored and the live tick.
            if (!enable || state == IDLE) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable && (pending || tick)) begin
                        state     <= XFER;
                        m_awaddr  <= LED_ADDR;
                        m_wdata   <= {24'h0, nxt};
                        m_wstrb   <= 4'b0001;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        next_q    <= nxt;
                        mode_q    <= mode;
                    end
                end
                XFER: begin
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wvalid && m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        state    <= RESP;
                        m_bready <= 1'b1;
                    end
                end
                RESP: begin
                    if (m_bvalid) begin
                        state    <= IDLE;
                        m_bready <= 1'b0;
                        if (m_bresp == 2'b00) begin
                            pattern <= next_q;
                            if (mode_q == 2'b11) begin
                                if (next_q == 8'h80) begin
                                    dir <= 1'b1;
                                end else if (next_q == 8'h01) begin
                                    dir <= 1'b0;
                                end
                            end
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
